// File: rtl/fir_coeff_seq_ctrl.sv
// fir_coeff_seq_ctrl: sequencing controller for a transposed-form FIR datapath.
// Loads a coefficient set into a single-port SRAM, then runs one TAPS-cycle
// read sweep per accepted sample. It drives the RAM strobes and the mul/acc/delay enables.
// Optional feature macro: FIR_COEFF_SYM_EN (symmetric coefficients, half-size load).
module fir_coeff_seq_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAPS   = 10,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                     iClk_12M,
    input  logic                     iRsn,
    input  logic                     iCoeffUpdateFlag,
    input  logic                     iCoeffValid,
    input  logic signed [DATA_W-1:0] iCoeffData,
    output logic                     oCoeffReady,
    input  logic                     iSampleValid,
    output logic                     oSampleReady,
    output logic                     oCsnRam,
    output logic                     oWrnRam,
    output logic        [ADDR_W-1:0] oAddrRam,
    output logic signed [DATA_W-1:0] oWrDtRam,
    output logic                     oEnMul,
    output logic        [ADDR_W-1:0] oTapIdx,
    output logic                     oEnAcc,
    output logic                     oEnDelay,
    output logic                     oOutValid,
    output logic                     oCoeffLoaded,
    output logic                     oErrOverrun
);

`ifdef FIR_COEFF_SYM_EN
    localparam int unsigned NLOAD = (TAPS + 1) / 2;
`else
    localparam int unsigned NLOAD = TAPS;
`endif

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W-1:0] LAST_WR  = ADDR_W'(NLOAD - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_READY = 3'd2;
    localparam logic [2:0] S_SWEEP = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    // Reject tap counts the address counters cannot cover
    generate
        if ((TAPS < 2) || (TAPS > (1 << ADDR_W))) begin : g_bad_taps
            $error("fir_coeff_seq_ctrl: TAPS must be in 2..2**ADDR_W");
        end
    endgenerate

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] rcnt_q, rcnt_d;
    logic              dcnt_q, dcnt_d;
    logic              en_mul_q;
    logic [ADDR_W-1:0] tap_idx_q;
    logic              en_acc_q;
    logic              out_valid_q;
    logic              loaded_q;
    logic              overrun_q;
    logic [ADDR_W-1:0] raddr_c;

    // Read address for the current sweep step (mirrored in symmetric mode)
`ifdef FIR_COEFF_SYM_EN
    logic [ADDR_W-1:0] mirror_c;
    always_comb begin
        mirror_c = LAST_TAP - rcnt_q;
        raddr_c  = (rcnt_q <= mirror_c) ? rcnt_q : mirror_c;
    end
`else
    always_comb begin
        raddr_c = rcnt_q;
    end
`endif

    // Next-state logic plus combinational RAM strobes and handshake readies
    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        rcnt_d       = rcnt_q;
        dcnt_d       = dcnt_q;
        oCoeffReady  = 1'b0;
        oSampleReady = 1'b0;
        oCsnRam      = 1'b1;
        oWrnRam      = 1'b1;
        oAddrRam     = '0;
        oWrDtRam     = '0;
        case (state_q)
            S_IDLE: begin
                if (iCoeffUpdateFlag) begin
                    state_d = S_LOAD;
                    wcnt_d  = '0;
                end
            end
            S_LOAD: begin
                oCoeffReady = 1'b1;
                if (iCoeffValid) begin
                    oCsnRam  = 1'b0;
                    oWrnRam  = 1'b0;
                    oAddrRam = wcnt_q;
                    oWrDtRam = iCoeffData;
                    if (wcnt_q == LAST_WR) begin
                        state_d = S_READY;
                        wcnt_d  = '0;
                    end else begin
                        wcnt_d = wcnt_q + ADDR_W'(1);
                    end
                end
            end
            S_READY: begin
                oSampleReady = !iCoeffUpdateFlag;
                if (iCoeffUpdateFlag) begin
                    state_d = S_LOAD;
                    wcnt_d  = '0;
                end else if (iSampleValid) begin
                    state_d = S_SWEEP;
                    rcnt_d  = '0;
                end
            end
            S_SWEEP: begin
                oCsnRam  = 1'b0;
                oAddrRam = raddr_c;
                if (rcnt_q == LAST_TAP) begin
                    state_d = S_DRAIN;
                    rcnt_d  = '0;
                    dcnt_d  = 1'b0;
                end else begin
                    rcnt_d = rcnt_q + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
                if (dcnt_q) begin
                    state_d = S_READY;
                    dcnt_d  = 1'b0;
                end else begin
                    dcnt_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, pipelined enables and status flags
    always_ff @(posedge iClk_12M) begin
        if (!iRsn) begin
            state_q     <= S_IDLE;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            dcnt_q      <= 1'b0;
            en_mul_q    <= 1'b0;
            tap_idx_q   <= '0;
            en_acc_q    <= 1'b0;
            out_valid_q <= 1'b0;
            loaded_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            dcnt_q      <= dcnt_d;
            en_mul_q    <= (state_q == S_SWEEP);
            tap_idx_q   <= (state_q == S_SWEEP) ? rcnt_q : '0;
            en_acc_q    <= en_mul_q;
            out_valid_q <= (state_q == S_DRAIN) && dcnt_q;
            loaded_q    <= (state_d == S_READY) || (state_d == S_SWEEP) ||
                           (state_d == S_DRAIN);
            if ((state_q != S_LOAD) && (state_d == S_LOAD)) begin
                overrun_q <= 1'b0;
            end else if (((state_q == S_SWEEP) || (state_q == S_DRAIN)) && iSampleValid) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign oEnMul       = en_mul_q;
    assign oTapIdx      = tap_idx_q;
    assign oEnAcc       = en_acc_q;
    assign oEnDelay     = out_valid_q;
    assign oOutValid    = out_valid_q;
    assign oCoeffLoaded = loaded_q;
    assign oErrOverrun  = overrun_q;

endmodule

// File: tb/tb_fir_coeff_seq_ctrl.sv
// Directed bench for fir_coeff_seq_ctrl: load, sweep timing, back-to-back,
// update priority and mid-sweep reset. Honours FIR_COEFF_SYM_EN if defined.
module tb_fir_coeff_seq_ctrl;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned TAPS   = 10;
    localparam int unsigned ADDR_W = 6;
`ifdef FIR_COEFF_SYM_EN
    localparam int NLOAD = (TAPS + 1) / 2;
`else
    localparam int NLOAD = TAPS;
`endif
    localparam int T  = TAPS;
    localparam int OW = 4 + ADDR_W + DATA_W + 1 + ADDR_W + 5;
    localparam logic [OW-1:0] RST_VEC = {2'b00, 2'b11, {(OW-4){1'b0}}};

    logic              clk = 1'b0;
    logic              rsn;
    logic              flag;
    logic              cvalid;
    logic [DATA_W-1:0] cdata;
    logic              coeff_ready;
    logic              svalid;
    logic              sample_ready;
    logic              csn, wrn;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wrdt;
    logic              en_mul;
    logic [ADDR_W-1:0] tap_idx;
    logic              en_acc, en_delay, out_valid, loaded, overrun;
    logic [OW-1:0]     outs;

    int tests_run = 0;
    int fails     = 0;

    fir_coeff_seq_ctrl #(.DATA_W(DATA_W), .TAPS(TAPS), .ADDR_W(ADDR_W)) dut (
        .iClk_12M(clk), .iRsn(rsn), .iCoeffUpdateFlag(flag),
        .iCoeffValid(cvalid), .iCoeffData(cdata), .oCoeffReady(coeff_ready),
        .iSampleValid(svalid), .oSampleReady(sample_ready),
        .oCsnRam(csn), .oWrnRam(wrn), .oAddrRam(addr), .oWrDtRam(wrdt),
        .oEnMul(en_mul), .oTapIdx(tap_idx), .oEnAcc(en_acc),
        .oEnDelay(en_delay), .oOutValid(out_valid),
        .oCoeffLoaded(loaded), .oErrOverrun(overrun)
    );

    assign outs = {coeff_ready, sample_ready, csn, wrn, addr, wrdt, en_mul,
                   tap_idx, en_acc, en_delay, out_valid, loaded, overrun};

    always #5 clk = ~clk;

    // Expected RAM read address for sweep step k
    function automatic logic [ADDR_W-1:0] exp_raddr(input int k);
`ifdef FIR_COEFF_SYM_EN
        int m;
        m = T - 1 - k;
        return ADDR_W'((k < m) ? k : m);
`else
        return ADDR_W'(k);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Plain stimulus: stream NLOAD coefficient words, no checks
    task automatic load_coeffs();
        flag = 1'b1; tick(); flag = 1'b0;
        for (int i = 0; i < NLOAD; i++) begin
            cvalid = 1'b1; cdata = DATA_W'(i + 1); tick();
        end
        cvalid = 1'b0; cdata = '0;
    endtask

    task automatic test_reset();
        rsn = 1'b0; flag = 1'b0; cvalid = 1'b0; cdata = '0; svalid = 1'b0;
        tick(); tick(); #1;
        tests_run++;
        if (outs !== RST_VEC) begin
            fails++; $display("FAIL reset_outputs: got %h want %h", outs, RST_VEC);
        end
        rsn = 1'b1; tick(); #1;
        tests_run++;
        if (coeff_ready !== 1'b0 || sample_ready !== 1'b0) begin
            fails++; $display("FAIL idle_readies: got cr=%b sr=%b want 0 0", coeff_ready, sample_ready);
        end
    endtask

    task automatic test_load();
        flag = 1'b1; tick(); flag = 1'b0;
        for (int i = 0; i < NLOAD; i++) begin
            if (i == 3) begin
                cvalid = 1'b0; #1;
                tests_run++;
                if (csn !== 1'b1 || coeff_ready !== 1'b1) begin
                    fails++; $display("FAIL load_gap: got csn=%b cr=%b want 1 1", csn, coeff_ready);
                end
                tick();
            end
            cvalid = 1'b1; cdata = DATA_W'(i + 1); #1;
            tests_run++;
            if (csn !== 1'b0 || wrn !== 1'b0 || addr !== ADDR_W'(i) ||
                wrdt !== DATA_W'(i + 1) || coeff_ready !== 1'b1 || loaded !== 1'b0) begin
                fails++;
                $display("FAIL load_word%0d: got csn=%b wrn=%b addr=%0d data=%h cr=%b ld=%b want 0 0 %0d %h 1 0",
                         i, csn, wrn, addr, wrdt, coeff_ready, loaded, i, i + 1);
            end
            tick();
        end
        cvalid = 1'b0; cdata = '0; #1;
        tests_run++;
        if (loaded !== 1'b1 || coeff_ready !== 1'b0 || sample_ready !== 1'b1 || csn !== 1'b1) begin
            fails++;
            $display("FAIL load_done: got ld=%b cr=%b sr=%b csn=%b want 1 0 1 1", loaded, coeff_ready, sample_ready, csn);
        end
    endtask

    task automatic test_sweep();
        logic              e_csn, e_mul, e_acc, e_ov, e_sr;
        logic [ADDR_W-1:0] e_addr;
        for (int c = 0; c <= T + 4; c++) begin
            svalid = (c == 0); #1;
            e_csn  = !(c >= 1 && c <= T);
            e_addr = e_csn ? '0 : exp_raddr(c - 1);
            e_mul  = (c >= 2 && c <= T + 1);
            e_acc  = (c >= 3 && c <= T + 2);
            e_ov   = (c == T + 3);
            e_sr   = (c == 0) || (c >= T + 3);
            tests_run++;
            if (csn !== e_csn || wrn !== 1'b1 || addr !== e_addr || en_mul !== e_mul ||
                (e_mul && tap_idx !== ADDR_W'(c - 2)) || en_acc !== e_acc ||
                out_valid !== e_ov || en_delay !== e_ov || sample_ready !== e_sr ||
                wrdt !== '0 || overrun !== 1'b0) begin
                fails++;
                $display("FAIL sweep_c%0d: got csn=%b wrn=%b addr=%0d mul=%b tap=%0d acc=%b ov=%b dl=%b sr=%b orun=%b want csn=%b wrn=1 addr=%0d mul=%b tap=%0d acc=%b ov=%b dl=%b sr=%b orun=0",
                         c, csn, wrn, addr, en_mul, tap_idx, en_acc, out_valid, en_delay, sample_ready, overrun,
                         e_csn, e_addr, e_mul, c - 2, e_acc, e_ov, e_ov, e_sr);
            end
            tick();
        end
        svalid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic e_csn, e_ov, e_sr, e_orun;
        for (int c = 0; c <= 2 * T + 8; c++) begin
            svalid = (c <= T + 3); #1;
            e_csn  = !((c >= 1 && c <= T) || (c >= T + 4 && c <= 2 * T + 3));
            e_ov   = (c == T + 3) || (c == 2 * T + 6);
            e_sr   = (c == 0) || (c == T + 3) || (c >= 2 * T + 6);
            e_orun = (c >= 2);
            tests_run++;
            if (csn !== e_csn || out_valid !== e_ov || en_delay !== e_ov ||
                sample_ready !== e_sr || overrun !== e_orun) begin
                fails++;
                $display("FAIL b2b_c%0d: got csn=%b ov=%b dl=%b sr=%b orun=%b want %b %b %b %b %b",
                         c, csn, out_valid, en_delay, sample_ready, overrun, e_csn, e_ov, e_ov, e_sr, e_orun);
            end
            tick();
        end
        svalid = 1'b0;
    endtask

    task automatic test_update_priority();
        flag = 1'b1; svalid = 1'b1; #1;
        tests_run++;
        if (sample_ready !== 1'b0 || coeff_ready !== 1'b0) begin
            fails++; $display("FAIL prio_ready: got sr=%b cr=%b want 0 0", sample_ready, coeff_ready);
        end
        tick();
        flag = 1'b0; #1;
        tests_run++;
        if (coeff_ready !== 1'b1 || csn !== 1'b1 || overrun !== 1'b0 || loaded !== 1'b0) begin
            fails++;
            $display("FAIL prio_load_entry: got cr=%b csn=%b orun=%b ld=%b want 1 1 0 0", coeff_ready, csn, overrun, loaded);
        end
        svalid = 1'b0;
        for (int i = 0; i < NLOAD + 3; i++) begin
            cvalid = (i < NLOAD); cdata = DATA_W'(16'h0100 + i); #1;
            tests_run++;
            if (en_mul !== 1'b0 || wrn !== !cvalid || csn !== !cvalid) begin
                fails++;
                $display("FAIL prio_no_sweep%0d: got mul=%b wrn=%b csn=%b want 0 %b %b", i, en_mul, wrn, csn, !cvalid, !cvalid);
            end
            tick();
        end
        cvalid = 1'b0; cdata = '0; #1;
        tests_run++;
        if (loaded !== 1'b1 || sample_ready !== 1'b1) begin
            fails++; $display("FAIL prio_reload_done: got ld=%b sr=%b want 1 1", loaded, sample_ready);
        end
    endtask

    task automatic test_reset_mid_sweep();
        for (int c = 0; c <= 5; c++) begin
            svalid = (c == 0);
            if (c == 5) rsn = 1'b0;
            tick();
        end
        #1;
        tests_run++;
        if (outs !== RST_VEC) begin
            fails++; $display("FAIL midsweep_reset: got %h want %h", outs, RST_VEC);
        end
        rsn = 1'b1; tick();
        for (int i = 0; i < 4; i++) begin
            svalid = 1'b1; #1;
            tests_run++;
            if (sample_ready !== 1'b0 || csn !== 1'b1 || en_mul !== 1'b0 || loaded !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_refuse%0d: got sr=%b csn=%b mul=%b ld=%b want 0 1 0 0", i, sample_ready, csn, en_mul, loaded);
            end
            tick();
        end
        svalid = 1'b0;
        load_coeffs();
        svalid = 1'b1; #1;
        tests_run++;
        if (sample_ready !== 1'b1) begin
            fails++; $display("FAIL post_reload_accept: got sr=%b want 1", sample_ready);
        end
        tick();
        svalid = 1'b0; #1;
        tests_run++;
        if (csn !== 1'b0 || wrn !== 1'b1 || addr !== exp_raddr(0)) begin
            fails++; $display("FAIL post_reload_sweep: got csn=%b wrn=%b addr=%0d want 0 1 %0d", csn, wrn, addr, exp_raddr(0));
        end
        for (int i = 0; i < T + 4; i++) tick();
    endtask

    initial begin
        test_reset();
        test_load();
        test_sweep();
        test_back_to_back();
        test_update_priority();
        test_reset_mid_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/fir_coeff_seq_ctrl.md
# fir_coeff_seq_ctrl

Parametrised FIR sequencing controller for the transposed-form filter datapath. It streams a full coefficient set into the single-port coefficient SRAM, then runs one TAPS-cycle read sweep per accepted input sample. For each tap it generates the RAM strobes, the multiplier enable, the accumulator enable and the delay-line shift. It sits between the sample/coefficient sources and the SpSram plus MAC/delay datapath, with ready/valid handshakes on both inputs.

## Interface
- DATA_W, 16, coefficient width
- TAPS, 10, number of filter taps (2..2^ADDR_W)
- ADDR_W, 6, coefficient RAM address width
- iClk_12M  in  1  system clock
- iRsn  in  1  reset; synchronous and active-low
- iCoeffUpdateFlag  in  1  request to (re)load coefficients
- iCoeffValid  in  1  coefficient word valid
- iCoeffData  in  DATA_W  coefficient word, signed
- oCoeffReady  out  1  controller accepts coefficient words
- iSampleValid  in  1  new input sample present
- oSampleReady  out  1  controller accepts a sample
- oCsnRam  out  1  RAM chip select, active-low
- oWrnRam  out  1  RAM write enable, active-low
- oAddrRam  out  ADDR_W  RAM address
- oWrDtRam  out  DATA_W  RAM write data
- oEnMul  out  1  RAM read data valid; multiply this tap
- oTapIdx  out  ADDR_W  tap index that goes with oEnMul
- oEnAcc  out  1  accumulate enable
- oEnDelay  out  1  transposed delay-line shift, one pulse per sample
- oOutValid  out  1  filter output valid pulse
- oCoeffLoaded  out  1  a complete coefficient set is in RAM
- oErrOverrun  out  1  sticky: sample offered while busy

## Operation
- States: IDLE, LOAD, READY, SWEEP, DRAIN.
- IDLE (after reset):
  - oCoeffLoaded=0.
  - iCoeffUpdateFlag=1 -> LOAD.
  - Samples are not accepted.
- LOAD:
  - oCoeffReady=1, and write counter wcnt starts at 0.
  - Each iCoeffValid cycle drives oCsnRam=0, oWrnRam=0, oAddrRam=wcnt, oWrDtRam=iCoeffData, then wcnt+1.
  - Writes are combinational on the cycle of the handshake.
  - When the last word (wcnt=NLOAD-1) is written -> READY and oCoeffLoaded=1.
  - NLOAD=TAPS.
  - Deasserting iCoeffUpdateFlag mid-load is ignored; the load completes.
- READY:
  - oSampleReady = !iCoeffUpdateFlag.
  - iCoeffUpdateFlag=1 -> LOAD (update has priority; a simultaneous sample is not accepted).
  - Otherwise iSampleValid=1 -> SWEEP.
- SWEEP:
  - Read counter rcnt runs 0..TAPS-1, one per cycle.
  - oCsnRam=0, oWrnRam=1, oAddrRam=raddr(rcnt).
  - After rcnt=TAPS-1 -> DRAIN.
- DRAIN: 2 cycles, then -> READY.
- oEnMul/oTapIdx are the SWEEP read strobe/rcnt delayed 1 cycle, matching the 1-cycle RAM read latency.
- oEnAcc is oEnMul delayed 1 cycle.
- oOutValid and oEnDelay pulse together for 1 cycle, in the cycle after the last oEnAcc.
- Outside LOAD writes and SWEEP:
  - oCsnRam=1, oWrnRam=1.
  - oAddrRam=0, oWrDtRam=0.
- Overrun: iSampleValid=1 in SWEEP or DRAIN sets oErrOverrun. The sample is dropped. The flag clears only on reset or on entering LOAD.
- Coefficients are treated as signed but pass through unmodified; the controller does no arithmetic beyond the counters.
- Counters are ADDR_W wide and never wrap, since the terminal compare happens before wrap. TAPS>2^ADDR_W is an elaboration error.

## Timing
- Reset value of every output is 0, except oCsnRam=1 and oWrnRam=1.
- Reset state is IDLE with wcnt=rcnt=0.
- Reset asserted mid-LOAD or mid-SWEEP:
  - Returns to IDLE next edge and oCoeffLoaded=0.
  - RAM content is not trusted; a reload is required.
  - Pipelined enables clear on the same edge.
- Sample accepted at edge of cycle 0 (READY, valid & ready):
  - Read addresses in cycles 1..TAPS.
  - oEnMul in 2..TAPS+1.
  - oEnAcc in 3..TAPS+2.
  - oOutValid/oEnDelay in TAPS+3.
- oSampleReady is high again in cycle TAPS+3, so throughput is one sample per TAPS+3 cycles.
- Coefficient load takes NLOAD accepted handshakes. Gaps in iCoeffValid stall the load without penalty.

## Configuration
- FIR_COEFF_SYM_EN defined (symmetric-coefficient mode):
  - NLOAD=ceil(TAPS/2).
  - raddr(k)=min(k, TAPS-1-k).
  - oTapIdx still reports k.
  - Sweep length is unchanged.
- Not defined: NLOAD=TAPS and raddr(k)=k.

## Test plan
- Reset, flag=1, 10 words 0x0001..0x000A with TAPS=10 -> writes at addresses 0..9 with matching data; oCoeffLoaded=1 after the 10th; LOAD lasts exactly 10 handshakes.
- Sample at cycle 0:
  - oAddrRam 0..9 in cycles 1..10.
  - oEnMul 2..11 with oTapIdx 0..9.
  - oEnAcc 3..12.
  - Single oOutValid/oEnDelay pulse at cycle 13.
- Back-to-back samples held valid -> second accepted at cycle 13, its oOutValid at 26; oErrOverrun set because valid stayed high during SWEEP; oErrOverrun cleared by a new LOAD.
- flag=1 and iSampleValid=1 together in READY -> oSampleReady=0, state goes to LOAD, no read sweep.
- iRsn=0 at cycle 5 of a sweep -> next cycle all outputs at reset values, oCoeffLoaded=0; a sample offered afterwards is not accepted until a reload completes.
- FIR_COEFF_SYM_EN, TAPS=10 -> load ends after 5 words; sweep addresses 0,1,2,3,4,4,3,2,1,0.
